// File: rtl/equiv_stim_driver.sv
// equiv_stim_driver: LFSR stimulus source and y_1/y_2 mismatch collector; EQUIV_DIFF_CAPTURE_EN adds first-fail diff/vector capture
module equiv_stim_driver #(
  parameter logic [88:0] SEED = 89'h1,
  parameter int WARMUP = 4,
  parameter int NUM_VECTORS = 1024,
  parameter int Y_W = 91
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [Y_W-1:0]    y_1,
  input  logic [Y_W-1:0]    y_2,
  output logic [21:0]       wire0,
  output logic [17:0]       wire1,
  output logic [21:0]       wire2,
  output logic signed [20:0] wire3,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       mismatch_cnt,
  output logic              first_fail_valid,
`ifdef EQUIV_DIFF_CAPTURE_EN
  output logic [15:0]       first_fail_idx,
  output logic [Y_W-1:0]    fail_diff,
  output logic [82:0]       fail_vec
`else
  output logic [15:0]       first_fail_idx
`endif
);
  typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} state_t;
  localparam logic [88:0] S0 = (SEED == '0) ? 89'h1 : SEED;
  localparam logic [7:0] WL = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [15:0] NL = 16'(NUM_VECTORS - 1);
  state_t st, nxt;
  logic [88:0] s;
  logic [7:0] wcnt;
  logic [15:0] idx;
  logic go, step, miss;
  assign go = !stop && start && (st == IDLE || st == DONE);
  assign step = !stop && (st == WARM || st == RUN);
  assign miss = st == RUN && y_1 != y_2;
  assign wire0 = s[21:0];
  assign wire1 = s[39:22];
  assign wire2 = s[61:40];
  assign wire3 = $signed(s[82:62]);
  // state register
  always_ff @(posedge clk)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  // next state and status outputs; stop overrides everything
  always_comb begin
    nxt = st;
    busy = st == WARM || st == RUN;
    done = st == DONE;
    pass = st == DONE && mismatch_cnt == '0;
    if (stop) nxt = IDLE;
    else if (go) nxt = WARMUP == 0 ? RUN : WARM;
    else if (st == WARM && wcnt == WL) nxt = RUN;
    else if (st == RUN && idx == NL) nxt = DONE;
  end
  // LFSR stepping, warmup/run counters and mismatch bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= '0;
      wcnt <= '0;
      idx <= '0;
      mismatch_cnt <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
    end else if (go) begin
      s <= S0;
      wcnt <= '0;
      idx <= '0;
      mismatch_cnt <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
    end else if (step) begin
      s <= {s[87:0], s[88] ^ s[37]};
      wcnt <= st == WARM ? wcnt + 8'd1 : wcnt;
      idx <= st == RUN ? idx + 16'd1 : idx;
      if (miss) begin
        mismatch_cnt <= mismatch_cnt == 16'hFFFF ? mismatch_cnt : mismatch_cnt + 16'd1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx <= idx;
        end
      end
    end
  end
`ifdef EQUIV_DIFF_CAPTURE_EN
  // latch the first differing output pattern and the vector that produced it
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      fail_diff <= '0;
      fail_vec <= '0;
    end else if (step && miss && !first_fail_valid) begin
      fail_diff <= y_1 ^ y_2;
      fail_vec <= s[82:0];
    end
  end
`endif
endmodule

// File: doc/equiv_stim_driver.md
Name: equiv_stim_driver

Overview:
- Stimulus source and result collector for the dual-instance equivalence harness.
- Drives the shared inputs wire0..wire3 with a pseudo-random LFSR sequence.
- Samples y_1/y_2 of the two DUT copies every RUN cycle; counts mismatches and records the first failing vector index.
- Sits in front of the harness top, sharing its clk; reports pass/done to the fuzz flow.

Parameters:
- SEED, 89'h1, initial LFSR state; an all-zero value is replaced by 89'h1.
- WARMUP, 4, cycles driven with comparison disabled (DUT registers settle); range 0..255.
- NUM_VECTORS, 1024, compared cycles per run; range 1..65535.
- Y_W, 91, width of y_1/y_2.

Ports:
- clk  input  1  rising-edge clock, shared with the DUT pair
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a run; honoured only in IDLE or DONE
- stop  input  1  abort; forces IDLE next edge
- y_1  input  Y_W  output of DUT copy 1
- y_2  input  Y_W  output of DUT copy 2
- wire0  output  22  stimulus = s[21:0]
- wire1  output  18  stimulus = s[39:22]
- wire2  output  22  stimulus = s[61:40]
- wire3  output  21 (signed)  stimulus = s[82:62]
- busy  output  1  high in WARMUP or RUN
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 iff mismatch_cnt==0
- mismatch_cnt  output  16  saturating mismatch count
- first_fail_valid  output  1  a mismatch has been recorded this run
- first_fail_idx  output  16  RUN index of the first mismatch

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, s=0, all outputs 0. Reset mid-run abandons the run; no residue.
- LFSR s[88:0], Fibonacci: fb = s[88]^s[37]; s_next = {s[87:0], fb}. One step per cycle in WARMUP and RUN; held in IDLE and DONE.
- wire outputs are direct slices of the registered s; they change only on clk edges.
- IDLE -> WARMUP on start.
  - s <= SEED (0 mapped to 1); counters, first_fail_* and pass cleared.
  - If WARMUP==0, go directly to RUN.
- WARMUP: cycle counter runs 0..WARMUP-1; no comparison. Then RUN with run index i=0.
- RUN: at each edge, compare y_1 != y_2.
  - On mismatch: mismatch_cnt += 1, saturating at 16'hFFFF.
  - On the first mismatch: first_fail_idx <= i and first_fail_valid <= 1.
  - i increments per cycle; after the compare at i=NUM_VECTORS-1, go to DONE.
- DONE: done=1, pass=(mismatch_cnt==0); s and results are frozen. start re-enters WARMUP, identical to the IDLE transition.
- stop: in any state, next state is IDLE with done=busy=pass=0. mismatch_cnt and first_fail_* hold until the next start.
- stop and start together: stop wins.
- start in WARMUP or RUN: ignored.
- Comparison is sampled at the edge closing the cycle. The DUT outputs are expected to reflect the vector of the same or an earlier cycle; WARMUP covers the pipeline depth.

Optional Feature:
- Macro: EQUIV_DIFF_CAPTURE_EN.
- Defined:
  - adds output fail_diff [Y_W-1:0] = y_1^y_2 latched at the first mismatch;
  - adds output fail_vec [82:0] = s[82:0] latched at the same edge;
  - both are cleared on reset and on start.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 edges mid-RUN -> IDLE, wire0..3=0, busy=done=pass=0, mismatch_cnt=0.
- LFSR sequence (SEED=1, WARMUP=0): one cycle after start, wire0=1; next cycle wire0=2; after 22 steps wire0=0 and wire1=1; wire2=wire3=0 throughout.
- Clean run (WARMUP=2, NUM_VECTORS=8, y_2=y_1):
  - busy for 10 cycles, then done=1, pass=1, mismatch_cnt=0, first_fail_valid=0.
  - done holds until start.
- Injected faults (same params, y_2 bit0 flipped at RUN indices 3 and 5):
  - mismatch_cnt=2, first_fail_idx=3, first_fail_valid=1, pass=0.
  - With EQUIV_DIFF_CAPTURE_EN: fail_diff=1.
- Abort: stop at RUN index 4 -> IDLE next cycle, busy=0, done=0. Asserting start and stop on the same edge stays in IDLE; a later start restarts with wire0=1 again (SEED=1).
- Saturation: NUM_VECTORS=65535 with y_2=~y_1 -> mismatch_cnt=16'hFFFF, first_fail_idx=0.
